// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// the stall bus type, stall-pattern constants and FSM state encodings.
package pipeline_ctrl_pkg;

   localparam int STALL_W      = 6;
   localparam int STALL_EX_BIT = 3;

   // Bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
   typedef logic [STALL_W-1:0] stall_bus_t;

   localparam stall_bus_t STALL_NONE    = 6'b000000;
   localparam stall_bus_t STALL_LOADUSE = 6'b000111;
   localparam stall_bus_t STALL_MD      = 6'b001111;
   localparam stall_bus_t STALL_MEM     = 6'b011111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } md_state_t;

endpackage

// File: rtl/md_latency_cnt.sv
// Load/decrement counter tracking the remaining mul/div latency,
// with a terminal flag raised when one cycle is left.
module md_latency_cnt #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_clear,
   input  logic             i_dec,
   output logic             o_is_one
);

   logic [CNT_W-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_is_one = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer and mul/div latency controller for the five-stage pipeline.
// Optional feature macro: PIPE_CTRL_PERF_EN adds stall_cycles / md_ops performance counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MUL_LATENCY = 4,
   parameter int DIV_LATENCY = 33,
   parameter int CNT_W       = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_use_req,
   input  logic               mem_stall_req,
   input  logic               flush_req,
   input  logic               md_req,
   input  logic               md_is_div,
   output logic [STALL_W-1:0] stall,
   output logic               flush,
   output logic               md_start,
   output logic               md_abort,
   output logic               md_busy,
   output logic               hilo_write_en
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]        stall_cycles,
   output logic [31:0]        md_ops
`endif
);

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

   md_state_t        r_state;
   logic             r_md_busy;
   logic             w_in_idle;
   logic             w_in_run;
   logic             w_in_done;
   logic             w_md_active;
   logic             w_md_start;
   logic             w_cnt_is_one;
   logic [CNT_W-1:0] w_lat_load;
   stall_bus_t       w_stall;

   assign w_in_idle  = (r_state == ST_IDLE);
   assign w_in_run   = (r_state == ST_RUN);
   assign w_in_done  = (r_state == ST_DONE);
   assign w_lat_load = md_is_div ? DIV_LOAD : MUL_LOAD;

   // A start is deferred behind a mem stall and suppressed by flush or reset.
   assign w_md_start  = w_in_idle && md_req && !mem_stall_req && !flush_req && !rst;
   assign w_md_active = (w_in_idle && md_req) || w_in_run;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_stall = STALL_NONE;
      if (rst || flush_req) begin
         w_stall = STALL_NONE;
      end else if (mem_stall_req) begin
         w_stall = STALL_MEM;
      end else if (w_md_active) begin
         w_stall = STALL_MD;
      end else if (load_use_req) begin
         w_stall = STALL_LOADUSE;
      end
   end

   md_latency_cnt #(
      .CNT_W (CNT_W)
   ) u_md_latency_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_md_start),
      .i_load_val (w_lat_load),
      .i_clear    (flush_req && !w_in_idle),
      .i_dec      (w_in_run),
      .o_is_one   (w_cnt_is_one)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_md_busy <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_md_start) begin
                  r_state   <= ST_RUN;
                  r_md_busy <= 1'b1;
               end
            end
            ST_RUN: begin
               if (flush_req) begin
                  r_state   <= ST_IDLE;
                  r_md_busy <= 1'b0;
               end else if (w_cnt_is_one) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               // md_req is still high here; leaving straight to IDLE prevents a retrigger.
               if (flush_req || !mem_stall_req) begin
                  r_state   <= ST_IDLE;
                  r_md_busy <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_md_busy <= 1'b0;
            end
         endcase
      end
   end

   assign stall         = w_stall;
   assign flush         = flush_req && !rst;
   assign md_start      = w_md_start;
   assign md_abort      = flush_req && !rst && (w_in_run || w_in_done);
   assign md_busy       = r_md_busy && !rst;
   assign hilo_write_en = w_in_done && !mem_stall_req && !flush_req && !rst;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_md_ops;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= '0;
         r_md_ops       <= '0;
      end else begin
         if (w_stall[0]) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
         if (hilo_write_en) begin
            r_md_ops <= r_md_ops + 32'd1;
         end
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign md_ops       = r_md_ops;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   typedef struct packed {
      logic [5:0] stall;
      logic       fl;
      logic       st;
      logic       ab;
      logic       busy;
      logic       hilo;
   } out_t;

   typedef struct {
      int    cyc;
      out_t  exp;
      string name;
   } sb_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_use_req;
   logic       mem_stall_req;
   logic       flush_req;
   logic       md_req;
   logic       md_is_div;
   logic [5:0] stall;
   logic       flush;
   logic       md_start;
   logic       md_abort;
   logic       md_busy;
   logic       hilo_write_en;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] md_ops;
   int          m_stalls = 0;
   int          m_ops    = 0;
`endif

   sb_t sb_q[$];
   int  cyc   = 0;
   int  total = 0;
   int  bad   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipeline_ctrl #(
      .MUL_LATENCY (4),
      .DIV_LATENCY (33),
      .CNT_W       (6)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .load_use_req  (load_use_req),
      .mem_stall_req (mem_stall_req),
      .flush_req     (flush_req),
      .md_req        (md_req),
      .md_is_div     (md_is_div),
      .stall         (stall),
      .flush         (flush),
      .md_start      (md_start),
      .md_abort      (md_abort),
      .md_busy       (md_busy),
      .hilo_write_en (hilo_write_en)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .stall_cycles  (stall_cycles),
      .md_ops        (md_ops)
`endif
   );

   function automatic out_t o(input logic [5:0] s, input logic f, input logic st,
                              input logic ab, input logic bz, input logic h);
      out_t r;
      r.stall = s;
      r.fl    = f;
      r.st    = st;
      r.ab    = ab;
      r.busy  = bz;
      r.hilo  = h;
      return r;
   endfunction

   task automatic check(input string name, input out_t act, input out_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got stall=%b flush=%b start=%b abort=%b busy=%b hilo=%b, want stall=%b flush=%b start=%b abort=%b busy=%b hilo=%b",
                  name, cyc, act.stall, act.fl, act.st, act.ab, act.busy, act.hilo,
                  exp.stall, exp.fl, exp.st, exp.ab, exp.busy, exp.hilo);
      end
   endtask

   // Monitor: every cycle the DUT presents its outputs; compare when an expectation is queued for it.
   always @(negedge clk) begin
      out_t act;
      sb_t  e;
      act = o(stall, flush, md_start, md_abort, md_busy, hilo_write_en);
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
         e = sb_q.pop_front();
         check(e.name, act, e.exp);
      end
   end

   task automatic step(input string name, input logic r, input logic lu, input logic mem,
                       input logic fl, input logic mr, input logic div, input out_t exp);
      sb_t e;
      @(posedge clk);
      #1;
      rst           = r;
      load_use_req  = lu;
      mem_stall_req = mem;
      flush_req     = fl;
      md_req        = mr;
      md_is_div     = div;
      e.cyc  = cyc;
      e.exp  = exp;
      e.name = name;
      sb_q.push_back(e);
`ifdef PIPE_CTRL_PERF_EN
      if (r) begin
         m_stalls = 0;
         m_ops    = 0;
      end else begin
         if (exp.stall[0]) m_stalls++;
         if (exp.hilo) m_ops++;
      end
`endif
   endtask

   out_t z;

   initial begin
      z             = o(STALL_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst           = 1'b1;
      load_use_req  = 1'b0;
      mem_stall_req = 1'b0;
      flush_req     = 1'b0;
      md_req        = 1'b0;
      md_is_div     = 1'b0;

      // Reset: requests present during reset must not leak onto outputs.
      step("rst0", 1, 1, 0, 0, 1, 0, z);
      step("rst1", 1, 0, 0, 0, 0, 0, z);
      step("idle", 0, 0, 0, 0, 0, 0, z);

      // Single-cycle load-use.
      step("lu",     0, 1, 0, 0, 0, 0, o(STALL_LOADUSE, 0, 0, 0, 0, 0));
      step("lu_end", 0, 0, 0, 0, 0, 0, z);

      // Multiply, latency 4; load-use under a running multiply keeps the MD pattern.
      step("mul_t0", 0, 0, 0, 0, 1, 0, o(STALL_MD, 0, 1, 0, 0, 0));
      step("mul_t1", 0, 1, 0, 0, 1, 0, o(STALL_MD, 0, 0, 0, 1, 0));
      step("mul_t2", 0, 0, 0, 0, 1, 0, o(STALL_MD, 0, 0, 0, 1, 0));
      step("mul_t3", 0, 0, 0, 0, 1, 0, o(STALL_MD, 0, 0, 0, 1, 0));
      step("mul_t4", 0, 0, 0, 0, 1, 0, o(STALL_NONE, 0, 0, 0, 1, 1));
      step("mul_t5", 0, 0, 0, 0, 0, 0, z);

      // Start deferred by mem stall; mem stall during RUN does not freeze the counter.
      step("def_d0", 0, 0, 1, 0, 1, 0, o(STALL_MEM, 0, 0, 0, 0, 0));
      step("def_d1", 0, 0, 0, 0, 1, 0, o(STALL_MD, 0, 1, 0, 0, 0));
      step("def_d2", 0, 0, 1, 0, 1, 0, o(STALL_MEM, 0, 0, 0, 1, 0));
      step("def_d3", 0, 0, 0, 0, 1, 0, o(STALL_MD, 0, 0, 0, 1, 0));
      step("def_d4", 0, 0, 0, 0, 1, 0, o(STALL_MD, 0, 0, 0, 1, 0));
      step("def_d5", 0, 0, 0, 0, 1, 0, o(STALL_NONE, 0, 0, 0, 1, 1));
      step("def_d6", 0, 0, 0, 0, 0, 0, z);

      // Divide: 33 stall cycles then one commit, then an immediate back-to-back multiply.
      step("div_t0", 0, 0, 0, 0, 1, 1, o(STALL_MD, 0, 1, 0, 0, 0));
      for (int i = 1; i <= 32; i++) begin
         step("div_run", 0, 0, 0, 0, 1, 1, o(STALL_MD, 0, 0, 0, 1, 0));
      end
      step("div_done", 0, 0, 0, 0, 1, 1, o(STALL_NONE, 0, 0, 0, 1, 1));
      step("b2b_t0",   0, 0, 0, 0, 1, 0, o(STALL_MD, 0, 1, 0, 0, 0));
      for (int i = 1; i <= 3; i++) begin
         step("b2b_run", 0, 0, 0, 0, 1, 0, o(STALL_MD, 0, 0, 0, 1, 0));
      end

      // Mem stall over DONE for 3 cycles: DONE held, single commit on release.
      for (int i = 0; i < 3; i++) begin
         step("done_mem", 0, 0, 1, 0, 1, 0, o(STALL_MEM, 0, 0, 0, 1, 0));
      end
      step("done_rel",  0, 0, 0, 0, 1, 0, o(STALL_NONE, 0, 0, 0, 1, 1));
      step("done_idle", 0, 0, 0, 0, 0, 0, z);

      // Flush in IDLE suppresses the start.
      step("fl_idle",  0, 0, 0, 1, 1, 0, o(STALL_NONE, 1, 0, 0, 0, 0));
      step("fl_idle2", 0, 0, 0, 0, 0, 0, z);

      // Flush at RUN cycle 2.
      step("fr_t0", 0, 0, 0, 0, 1, 0, o(STALL_MD, 0, 1, 0, 0, 0));
      step("fr_t1", 0, 0, 0, 0, 1, 0, o(STALL_MD, 0, 0, 0, 1, 0));
      step("fr_t2", 0, 0, 0, 1, 1, 0, o(STALL_NONE, 1, 0, 1, 1, 0));
      step("fr_t3", 0, 0, 0, 0, 0, 0, z);

      // Flush in DONE: abort, no commit.
      step("fd_t0", 0, 0, 0, 0, 1, 0, o(STALL_MD, 0, 1, 0, 0, 0));
      for (int i = 1; i <= 3; i++) begin
         step("fd_run", 0, 0, 0, 0, 1, 0, o(STALL_MD, 0, 0, 0, 1, 0));
      end
      step("fd_t4", 0, 0, 0, 1, 1, 0, o(STALL_NONE, 1, 0, 1, 1, 0));
      step("fd_t5", 0, 0, 0, 0, 0, 0, z);

      // Reset mid-RUN, then a full-latency restart; load-use in DONE stalls ID and earlier only.
      step("rr_t0", 0, 0, 0, 0, 1, 0, o(STALL_MD, 0, 1, 0, 0, 0));
      step("rr_t1", 0, 0, 0, 0, 1, 0, o(STALL_MD, 0, 0, 0, 1, 0));
      step("rr_rst", 1, 0, 0, 0, 1, 0, z);
      step("rr_t3", 0, 0, 0, 0, 1, 0, o(STALL_MD, 0, 1, 0, 0, 0));
      for (int i = 1; i <= 3; i++) begin
         step("rr_run", 0, 0, 0, 0, 1, 0, o(STALL_MD, 0, 0, 0, 1, 0));
      end
      step("rr_done", 0, 1, 0, 0, 1, 0, o(STALL_LOADUSE, 0, 0, 0, 1, 1));
      step("rr_end",  0, 0, 0, 0, 0, 0, z);

      @(negedge clk);
`ifdef PIPE_CTRL_PERF_EN
      total++;
      if (stall_cycles !== 32'(m_stalls)) begin
         bad++;
         $display("FAIL perf_stall_cycles: got %0d want %0d", stall_cycles, m_stalls);
      end
      total++;
      if (md_ops !== 32'(m_ops)) begin
         bad++;
         $display("FAIL perf_md_ops: got %0d want %0d", md_ops, m_ops);
      end
`endif
      @(posedge clk);
      @(negedge clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: pending=%0d want 0", sb_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
